paging_tlb: RTL and testbench

Parametrised paging unit that replaces the CPU's internal direct-indexed page-table array with a fully associative TLB backed by a hardware page-table walker. Sits between the CPU's MAR and the RAM address port. Translates virtual to physical addresses, refills misses by reading PTEs from RAM through a request/acknowledge port, and reports page and protection faults with the faulting virtual address captured.

---
 rtl/paging_pkg.sv | 22 ++
 rtl/paging_tlb_if.sv | 32 +++
 rtl/tlb_cam.sv | 86 ++++++++
 rtl/paging_tlb.sv | 157 +++++++++++++++
 tb/tb_paging_tlb.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/paging_pkg.sv
// Shared types and helpers for the paging unit.
// Walker states, PTE bit positions and derived widths.
package paging_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WALK,
        S_RESP
    } state_e;

    localparam int PTE_PRESENT = 0;
    localparam int PTE_SUP     = 1;

    function automatic int vpn_width(int va_w, int page_bits);
        return va_w - page_bits;
    endfunction

    function automatic int pfn_width(int pa_w, int page_bits);
        return pa_w - page_bits;
    endfunction

endpackage

// File: rtl/paging_tlb_if.sv
// CPU request/response and PTE read port of the paging unit.
// master = CPU/memory side, slave = paging unit.
interface paging_tlb_if #(
    parameter int VA_W  = 16,
    parameter int PA_W  = 19,
    parameter int PTE_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [VA_W-1:0]  req_vaddr;
    logic             resp_valid;
    logic [PA_W-1:0]  resp_paddr;
    logic             page_fault;
    logic             prot_fault;
    logic [VA_W-1:0]  fault_vaddr;
    logic             mem_rd_req;
    logic [PA_W-1:0]  mem_rd_addr;
    logic             mem_rd_ack;
    logic [PTE_W-1:0] mem_rd_data;

    modport master (
        output req_valid, req_vaddr, mem_rd_ack, mem_rd_data,
        input  req_ready, resp_valid, resp_paddr, page_fault,
        input  prot_fault, fault_vaddr, mem_rd_req, mem_rd_addr
    );

    modport slave (
        input  req_valid, req_vaddr, mem_rd_ack, mem_rd_data,
        output req_ready, resp_valid, resp_paddr, page_fault,
        output prot_fault, fault_vaddr, mem_rd_req, mem_rd_addr
    );
endinterface

// File: rtl/tlb_cam.sv
// Fully associative TLB storage: parallel VPN match,
// victim selection (first free, else round-robin), flush/invalidate.
module tlb_cam #(
    parameter int VPN_W   = 5,
    parameter int PFN_W   = 8,
    parameter int ENTRIES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [VPN_W-1:0] lookup_vpn_i,
    output logic             hit_o,
    output logic [PFN_W-1:0] hit_pfn_o,
    output logic             hit_sup_o,
    input  logic             flush_i,
    input  logic             inv_valid_i,
    input  logic [VPN_W-1:0] inv_vpn_i,
    input  logic             fill_i,
    input  logic [VPN_W-1:0] fill_vpn_i,
    input  logic [PFN_W-1:0] fill_pfn_i,
    input  logic             fill_sup_i
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] valid_q;
    logic [VPN_W-1:0]   vpn_q [ENTRIES];
    logic [PFN_W-1:0]   pfn_q [ENTRIES];
    logic               sup_q [ENTRIES];
    logic [IDX_W-1:0]   rr_q;
    logic [IDX_W-1:0]   victim;
    logic               full;

    always_comb begin
        hit_o     = 1'b0;
        hit_pfn_o = '0;
        hit_sup_o = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && vpn_q[i] == lookup_vpn_i) begin
                hit_o     = 1'b1;
                hit_pfn_o = hit_pfn_o | pfn_q[i];
                hit_sup_o = hit_sup_o | sup_q[i];
            end
        end
    end

    always_comb begin
        victim = rr_q;
        full   = 1'b1;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                victim = IDX_W'(i);
                full   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            rr_q    <= '0;
        end else begin
            if (fill_i) begin
                valid_q[victim] <= 1'b1;
                if (full) rr_q <= rr_q + IDX_W'(1);
            end
            if (flush_i) begin
                valid_q <= '0;
            end else if (inv_valid_i) begin
                // the slot being overwritten this cycle must keep its new fill
                for (int i = 0; i < ENTRIES; i++) begin
                    if (valid_q[i] && vpn_q[i] == inv_vpn_i &&
                        !(fill_i && IDX_W'(i) == victim))
                        valid_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_i) begin
            vpn_q[victim] <= fill_vpn_i;
            pfn_q[victim] <= fill_pfn_i;
            sup_q[victim] <= fill_sup_i;
        end
    end

endmodule

// File: rtl/paging_tlb.sv
// Paging unit: TLB lookup plus page-table walker between MAR and RAM.
// Misses read one PTE from RAM; faults capture the virtual address.
module paging_tlb
    import paging_pkg::*;
#(
    parameter int VA_W      = 16,
    parameter int PA_W      = 19,
    parameter int PAGE_BITS = 11,
    parameter int ENTRIES   = 8,
    parameter int PTE_W     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         paging_en,
    input  logic                         user_mode,
    input  logic [PA_W-1:0]              ptb,
    input  logic                         flush,
    input  logic                         inv_valid,
    input  logic [VA_W-PAGE_BITS-1:0]    inv_vpn,
    paging_tlb_if.slave                  bus
);
    localparam int VPN_W     = vpn_width(VA_W, PAGE_BITS);
    localparam int PFN_W     = pfn_width(PA_W, PAGE_BITS);
    localparam int PTE_BYTES = PTE_W / 8;

    state_e          state_q;
    logic            ready_q;
    logic            resp_valid_q;
    logic            pf_q;
    logic            prf_q;
    logic [PA_W-1:0] paddr_q;
    logic [VA_W-1:0] fva_q;
    logic            rd_req_q;
    logic [PA_W-1:0] rd_addr_q;
    logic            discard_q;
    logic [VA_W-1:0] vaddr_q;

    logic [VPN_W-1:0] req_vpn;
    logic [VPN_W-1:0] walk_vpn;
    logic [PA_W-1:0]  pte_addr;
    logic [PFN_W-1:0] pte_pfn;
    logic             pte_present;
    logic             pte_sup;
    logic             inv_hit;
    logic             fill_en;
    logic             hit;
    logic [PFN_W-1:0] hit_pfn;
    logic             hit_sup;
    logic             unused_pte;

    assign req_vpn     = bus.req_vaddr[VA_W-1 -: VPN_W];
    assign walk_vpn    = vaddr_q[VA_W-1 -: VPN_W];
    assign pte_addr    = ptb + PA_W'(req_vpn) * PA_W'(PTE_BYTES);
    assign pte_pfn     = bus.mem_rd_data[PTE_W-1 -: PFN_W];
    assign pte_present = bus.mem_rd_data[PTE_PRESENT];
    assign pte_sup     = bus.mem_rd_data[PTE_SUP];
    assign unused_pte  = ^bus.mem_rd_data;
    assign inv_hit     = inv_valid && inv_vpn == walk_vpn;
    // a flush or invalidate seen at any point of the walk voids the fill
    assign fill_en     = state_q == S_WALK && bus.mem_rd_ack && pte_present &&
                         !(discard_q || flush || inv_hit);

    tlb_cam #(
        .VPN_W   (VPN_W),
        .PFN_W   (PFN_W),
        .ENTRIES (ENTRIES)
    ) u_cam (
        .clk          (clk),
        .reset        (reset),
        .lookup_vpn_i (req_vpn),
        .hit_o        (hit),
        .hit_pfn_o    (hit_pfn),
        .hit_sup_o    (hit_sup),
        .flush_i      (flush),
        .inv_valid_i  (inv_valid),
        .inv_vpn_i    (inv_vpn),
        .fill_i       (fill_en),
        .fill_vpn_i   (walk_vpn),
        .fill_pfn_i   (pte_pfn),
        .fill_sup_i   (pte_sup)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            pf_q         <= 1'b0;
            prf_q        <= 1'b0;
            paddr_q      <= '0;
            fva_q        <= '0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            discard_q    <= 1'b0;
            vaddr_q      <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        ready_q   <= 1'b0;
                        vaddr_q   <= bus.req_vaddr;
                        discard_q <= 1'b0;
                        if (!paging_en) begin
                            paddr_q      <= PA_W'(bus.req_vaddr);
                            pf_q         <= 1'b0;
                            prf_q        <= 1'b0;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else if (hit) begin
                            paddr_q      <= {hit_pfn, bus.req_vaddr[PAGE_BITS-1:0]};
                            pf_q         <= 1'b0;
                            prf_q        <= user_mode & hit_sup;
                            if (user_mode & hit_sup) fva_q <= bus.req_vaddr;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else begin
                            rd_req_q  <= 1'b1;
                            rd_addr_q <= pte_addr;
                            state_q   <= S_WALK;
                        end
                    end
                end
                S_WALK: begin
                    if (flush || inv_hit) discard_q <= 1'b1;
                    if (bus.mem_rd_ack) begin
                        rd_req_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        paddr_q      <= {pte_pfn, vaddr_q[PAGE_BITS-1:0]};
                        pf_q         <= !pte_present;
                        prf_q        <= pte_present & user_mode & pte_sup;
                        if (!pte_present || (user_mode && pte_sup))
                            fva_q <= vaddr_q;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    resp_valid_q <= 1'b0;
                    pf_q         <= 1'b0;
                    prf_q        <= 1'b0;
                    ready_q      <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = ready_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_paddr  = paddr_q;
    assign bus.page_fault  = pf_q;
    assign bus.prot_fault  = prf_q;
    assign bus.fault_vaddr = fva_q;
    assign bus.mem_rd_req  = rd_req_q;
    assign bus.mem_rd_addr = rd_addr_q;

endmodule

// File: tb/tb_paging_tlb.sv
// Bench for paging_tlb: directed vector table, corner sequences,
// then random traffic against a behavioural TLB model.
module tb_paging_tlb;
    logic        clk = 1'b0;
    logic        reset;
    logic        paging_en;
    logic        user_mode;
    logic [18:0] ptb;
    logic        flush;
    logic        inv_valid;
    logic [4:0]  inv_vpn;

    paging_tlb_if #(.VA_W(16), .PA_W(19), .PTE_W(16)) bus ();

    paging_tlb #(
        .VA_W(16), .PA_W(19), .PAGE_BITS(11), .ENTRIES(8), .PTE_W(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .paging_en (paging_en),
        .user_mode (user_mode),
        .ptb       (ptb),
        .flush     (flush),
        .inv_valid (inv_valid),
        .inv_vpn   (inv_vpn),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] pte_tab [32];

    // behavioural model: slots, round-robin pointer, last fault address
    bit          m_v   [8];
    logic [4:0]  m_vpn [8];
    logic [7:0]  m_pfn [8];
    bit          m_sup [8];
    int          m_rr;
    logic [15:0] m_fva;

    typedef struct {
        logic [15:0] va;
        bit          um;
        bit          en;
        logic [15:0] pte;
        int          wt;
        bit          walk;
        logic [18:0] pa;
        bit          pf;
        bit          prf;
        logic [15:0] fva;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_flush();
        for (int i = 0; i < 8; i++) m_v[i] = 0;
    endtask

    task automatic model_reset();
        model_flush();
        m_rr  = 0;
        m_fva = 16'h0;
    endtask

    task automatic model_inv(input logic [4:0] vpn);
        for (int i = 0; i < 8; i++)
            if (m_v[i] && m_vpn[i] == vpn) m_v[i] = 0;
    endtask

    task automatic model_acc(input logic [15:0] va, input bit um, input bit en,
                             input int mid, output bit walk,
                             output logic [18:0] pa, output bit pf,
                             output bit prf);
        logic [4:0]  vpn = va[15:11];
        logic [15:0] pte;
        int idx = -1;
        int vic = -1;
        walk = 0; pf = 0; prf = 0;
        if (!en) begin
            pa = {3'b000, va};
            return;
        end
        for (int i = 0; i < 8; i++)
            if (m_v[i] && m_vpn[i] == vpn) idx = i;
        if (idx >= 0) begin
            pa  = {m_pfn[idx], va[10:0]};
            prf = um & m_sup[idx];
        end else begin
            walk = 1;
            pte  = pte_tab[vpn];
            pa   = {pte[15:8], va[10:0]};
            pf   = !pte[0];
            prf  = pte[0] & um & pte[1];
            if (mid == 1) model_flush();
            if (mid == 2) model_inv(vpn);
            if (pte[0] && mid == 0) begin
                for (int i = 7; i >= 0; i--) if (!m_v[i]) vic = i;
                if (vic < 0) begin
                    vic  = m_rr;
                    m_rr = (m_rr + 1) % 8;
                end
                m_v[vic]   = 1;
                m_vpn[vic] = vpn;
                m_pfn[vic] = pte[15:8];
                m_sup[vic] = pte[1];
            end
        end
        if (pf || prf) m_fva = va;
    endtask

    // drives one request and plays the PTE memory; tim flags any handshake
    // or timing rule broken along the way
    task automatic access(input logic [15:0] va, input bit um, input bit en,
                          input int wt, input int mid, output bit walked,
                          output logic [18:0] pa, output bit pf,
                          output bit prf, output logic [18:0] raddr,
                          output bit tim);
        int cyc = 1;
        int ack_cyc = 0;
        int waits = 0;
        bit done = 0;
        walked = 0; pa = '0; pf = 0; prf = 0; raddr = '0; tim = 1;
        @(negedge clk);
        if (bus.req_ready !== 1'b1) tim = 0;
        bus.req_valid = 1; bus.req_vaddr = va;
        user_mode = um; paging_en = en;
        @(negedge clk);
        bus.req_valid = 0;
        while (!done && cyc < 64) begin
            flush = 0; inv_valid = 0; bus.mem_rd_ack = 0;
            if (bus.resp_valid) begin
                pa = bus.resp_paddr; pf = bus.page_fault; prf = bus.prot_fault;
                done = 1;
                if (walked) tim &= (cyc == ack_cyc + 1);
                else        tim &= (cyc == 1);
            end else begin
                if (bus.mem_rd_req) begin
                    if (!walked) begin
                        walked = 1;
                        raddr  = bus.mem_rd_addr;
                        if (cyc != 1) tim = 0;
                        if (mid == 1) flush = 1;
                        if (mid == 2) begin inv_valid = 1; inv_vpn = va[15:11]; end
                    end else if (bus.mem_rd_addr !== raddr) begin
                        tim = 0;
                    end
                    if (waits >= wt) begin
                        bus.mem_rd_ack  = 1;
                        bus.mem_rd_data = pte_tab[va[15:11]];
                        ack_cyc = cyc;
                    end else begin
                        waits++;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        bus.mem_rd_ack = 0; flush = 0; inv_valid = 0;
        if (!done) begin
            chk("resp_timeout", 32'd0, 32'd1);
            tim = 0;
        end else begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) tim = 0;
        end
    endtask

    task automatic run(input string tag, input logic [15:0] va, input bit um,
                       input bit en, input int wt, input int mid,
                       output bit w, output logic [18:0] pa, output bit pf,
                       output bit prf);
        bit tim, mw, mpf, mprf;
        logic [18:0] mpa, ra, era;
        era = ptb + {14'b0, va[15:11]} * 19'd2;
        access(va, um, en, wt, mid, w, pa, pf, prf, ra, tim);
        model_acc(va, um, en, mid, mw, mpa, mpf, mprf);
        chk({tag, " walk"}, w, mw);
        if (!mpf) chk({tag, " paddr"}, pa, mpa);
        chk({tag, " page_fault"}, pf, mpf);
        chk({tag, " prot_fault"}, prf, mprf);
        chk({tag, " fault_vaddr"}, bus.fault_vaddr, m_fva);
        chk({tag, " timing"}, tim, 1);
        if (mw) chk({tag, " rd_addr"}, ra, era);
    endtask

    task automatic idle_flush();
        @(negedge clk); flush = 1;
        @(negedge clk); flush = 0;
        model_flush();
    endtask

    task automatic idle_inv(input logic [4:0] vpn);
        @(negedge clk); inv_valid = 1; inv_vpn = vpn;
        @(negedge clk); inv_valid = 0;
        model_inv(vpn);
    endtask

    initial begin
        bit w, pf, prf;
        logic [18:0] pa;

        vt[0] = '{16'h1234, 0, 0, 16'h0000, 0, 0, 19'h01234, 0, 0, 16'h0000};
        vt[1] = '{16'h0A05, 0, 1, 16'h3701, 2, 1, 19'h1BA05, 0, 0, 16'h0000};
        vt[2] = '{16'h0A05, 0, 1, 16'h3701, 0, 0, 19'h1BA05, 0, 0, 16'h0000};
        vt[3] = '{16'h2000, 0, 1, 16'h0000, 0, 1, 19'h00000, 1, 0, 16'h2000};
        vt[4] = '{16'h2000, 0, 1, 16'h0000, 1, 1, 19'h00000, 1, 0, 16'h2000};
        vt[5] = '{16'h2800, 1, 1, 16'h0503, 0, 1, 19'h02800, 0, 1, 16'h2800};
        vt[6] = '{16'h2810, 0, 1, 16'h0503, 0, 0, 19'h02810, 0, 0, 16'h2800};
        vt[7] = '{16'h2810, 1, 1, 16'h0503, 0, 0, 19'h02810, 0, 1, 16'h2810};

        reset = 1; paging_en = 0; user_mode = 0; ptb = 19'h00100;
        flush = 0; inv_valid = 0; inv_vpn = '0;
        bus.req_valid = 0; bus.req_vaddr = '0;
        bus.mem_rd_ack = 0; bus.mem_rd_data = '0;
        for (int i = 0; i < 32; i++) pte_tab[i] = 16'h0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst req_ready", bus.req_ready, 1);
        chk("rst resp_valid", bus.resp_valid, 0);
        chk("rst page_fault", bus.page_fault, 0);
        chk("rst prot_fault", bus.prot_fault, 0);
        chk("rst resp_paddr", bus.resp_paddr, 0);
        chk("rst fault_vaddr", bus.fault_vaddr, 0);
        chk("rst mem_rd_req", bus.mem_rd_req, 0);
        chk("rst mem_rd_addr", bus.mem_rd_addr, 0);
        reset = 0;

        for (int i = 0; i < 8; i++) begin
            pte_tab[vt[i].va[15:11]] = vt[i].pte;
            run($sformatf("vec%0d", i), vt[i].va, vt[i].um, vt[i].en,
                vt[i].wt, 0, w, pa, pf, prf);
            chk($sformatf("vec%0d walk_tbl", i), w, vt[i].walk);
            if (!vt[i].pf) chk($sformatf("vec%0d paddr_tbl", i), pa, vt[i].pa);
            chk($sformatf("vec%0d pf_tbl", i), pf, vt[i].pf);
            chk($sformatf("vec%0d prf_tbl", i), prf, vt[i].prf);
            chk($sformatf("vec%0d fva_tbl", i), bus.fault_vaddr, vt[i].fva);
        end

        // nine distinct pages into eight slots: slot 0 (VPN 0) is replaced
        idle_flush();
        for (int v = 0; v < 9; v++) begin
            pte_tab[v] = {8'h40 + 8'(v), 8'h01};
            run($sformatf("evict fill%0d", v), 16'(v) << 11, 0, 1, v % 3, 0,
                w, pa, pf, prf);
        end
        run("evict vpn8", 16'h4123, 0, 1, 0, 0, w, pa, pf, prf);
        chk("evict vpn8 hit", w, 0);
        chk("evict vpn8 paddr", pa, 19'h24123);
        run("evict vpn0", 16'h0042, 0, 1, 0, 0, w, pa, pf, prf);
        chk("evict vpn0 miss", w, 1);

        // flush mid-walk, then invalidate coinciding with the ack
        pte_tab[10] = 16'h6601;
        run("flush_walk", 16'h5000, 0, 1, 2, 1, w, pa, pf, prf);
        run("flush_walk again", 16'h5000, 0, 1, 0, 0, w, pa, pf, prf);
        chk("flush_walk rewalk", w, 1);
        pte_tab[11] = 16'h6701;
        run("inv_ack", 16'h5800, 0, 1, 0, 2, w, pa, pf, prf);
        run("inv_ack again", 16'h5800, 0, 1, 0, 0, w, pa, pf, prf);
        chk("inv_ack rewalk", w, 1);

        // PTE address wraps modulo 2^19
        ptb = 19'h7FFF8;
        pte_tab[12] = 16'h1101;
        begin
            bit tim;
            logic [18:0] ra;
            access(16'h6000, 0, 1, 0, 0, w, pa, pf, prf, ra, tim);
            chk("wrap rd_addr", ra, 19'h00010);
            chk("wrap paddr", pa, 19'h08800);
            model_acc(16'h6000, 0, 1, 0, w, pa, pf, prf);
        end
        ptb = 19'h00100;

        // reset while walking; the late ack must not produce a response
        idle_flush();
        @(negedge clk);
        bus.req_valid = 1; bus.req_vaddr = 16'h3000; paging_en = 1;
        @(negedge clk);
        bus.req_valid = 0;
        chk("rstwalk req", bus.mem_rd_req, 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("rstwalk req_low", bus.mem_rd_req, 0);
        chk("rstwalk ready", bus.req_ready, 1);
        chk("rstwalk fva", bus.fault_vaddr, 0);
        bus.mem_rd_ack = 1; bus.mem_rd_data = 16'h1201;
        @(negedge clk);
        bus.mem_rd_ack = 0;
        chk("rstwalk late_ack resp", bus.resp_valid, 0);
        chk("rstwalk late_ack req", bus.mem_rd_req, 0);
        chk("rstwalk late_ack ready", bus.req_ready, 1);
        model_reset();
        pte_tab[6] = 16'h1201;
        run("rstwalk after", 16'h3000, 0, 1, 0, 0, w, pa, pf, prf);

        // random traffic over 12 pages so evictions and refills recur
        for (int i = 0; i < 32; i++) begin
            pte_tab[i] = {8'($urandom), 6'b0, 1'($urandom % 3 == 0),
                          1'($urandom % 5 != 0)};
        end
        for (int n = 0; n < 400; n++) begin
            int r = $urandom % 20;
            if (r == 0) begin
                idle_flush();
            end else if (r == 1) begin
                idle_inv(5'($urandom % 12));
            end else begin
                logic [15:0] va;
                va = {5'($urandom % 12), 11'($urandom)};
                ptb = 19'($urandom);
                run($sformatf("rnd%0d", n), va, 1'($urandom), $urandom % 8 != 0,
                    $urandom % 4, (r == 2) ? 1 : (r == 3) ? 2 : 0,
                    w, pa, pf, prf);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
